persiana_motor_ctrl: RTL

- Downstream stage of the blind position FSM: consumes the 2-bit commanded position code P (00 closed, 01 half, 10 open) and drives the blind motor up/down until the tracked position matches.
- Tracks position with a tick-based travel counter, homes on the bottom limit after reset, and inserts dead time before every motor start/reversal.
- Detects limit-switch faults.

---
 rtl/persiana_motor_ctrl.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/persiana_motor_ctrl.sv
// Blind motor controller: follows the commanded position code with a tick-based
// travel counter, homes on the bottom limit after reset and flags limit faults.
module persiana_motor_ctrl #(
    parameter int TICK_DIV     = 1000,
    parameter int TRAVEL_TICKS = 100,
    parameter int HALF_TICKS   = 50,
    parameter int DEADTIME     = 4,
    parameter int POS_W        = 8
) (
    input  logic             reloj,
    input  logic             reset,
    input  logic [1:0]       cmd,
    input  logic             lim_top,
    input  logic             lim_bot,
    output logic             motor_up,
    output logic             motor_down,
    output logic [POS_W-1:0] pos,
    output logic             busy,
    output logic             fault
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = (DEADTIME > 1) ? $clog2(DEADTIME + 1) : 1;

    localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0]    DEAD_LAST  = DW'(DEADTIME - 1);
    localparam logic [POS_W-1:0] POS_OPEN   = POS_W'(TRAVEL_TICKS);
    localparam logic [POS_W-1:0] POS_HALF   = POS_W'(HALF_TICKS);
    localparam logic [POS_W-1:0] HOME_LAST  = POS_W'(2 * TRAVEL_TICKS - 1);

    localparam logic [2:0] ST_INIT    = 3'd0;
    localparam logic [2:0] ST_HOME    = 3'd1;
    localparam logic [2:0] ST_IDLE    = 3'd2;
    localparam logic [2:0] ST_DEAD    = 3'd3;
    localparam logic [2:0] ST_MOVE_UP = 3'd4;
    localparam logic [2:0] ST_MOVE_DN = 3'd5;
    localparam logic [2:0] ST_FAULT   = 3'd6;

    logic [2:0]       state;
    logic [2:0]       state_nx;
    logic [POS_W-1:0] pos_nx;
    logic [POS_W-1:0] target;
    logic [PW-1:0]    presc;
    logic [DW-1:0]    dcnt;
    logic [POS_W-1:0] htick;
    logic [1:0]       top_sync;
    logic [1:0]       bot_sync;
    logic             top;
    logic             bot;
    logic             motion;
    logic             tick;
    logic [POS_W-1:0] pos_inc;
    logic [POS_W-1:0] pos_dec;

    always_ff @(posedge reloj or posedge reset) begin
        if (reset) begin
            top_sync <= '0;
            bot_sync <= '0;
        end else begin
            top_sync <= {top_sync[0], lim_top};
            bot_sync <= {bot_sync[0], lim_bot};
        end
    end

    assign top = top_sync[1];
    assign bot = bot_sync[1];

    always_ff @(posedge reloj or posedge reset) begin
        if (reset) begin
            target <= '0;
        end else begin
            case (cmd)
                2'b00:   target <= '0;
                2'b01:   target <= POS_HALF;
                2'b10:   target <= POS_OPEN;
                default: target <= target;
            endcase
        end
    end

    assign motion  = (state == ST_HOME) || (state == ST_MOVE_UP) || (state == ST_MOVE_DN);
    assign tick    = motion && (presc == PRESC_LAST);
    assign pos_inc = (pos >= POS_OPEN) ? POS_OPEN : pos + 1'b1;
    assign pos_dec = (pos == '0) ? '0 : pos - 1'b1;

    // Arrival and reversal decisions in MOVE_* compare against the post-tick position.
    always_comb begin
        state_nx = state;
        pos_nx   = pos;
        case (state)
            ST_INIT: begin
                if (dcnt == DEAD_LAST) state_nx = ST_HOME;
            end
            ST_HOME: begin
                if (bot) begin
                    pos_nx   = '0;
                    state_nx = ST_IDLE;
                end else if (tick && (htick == HOME_LAST)) begin
                    state_nx = ST_FAULT;
                end
            end
            ST_IDLE: begin
                if (target != pos) state_nx = ST_DEAD;
            end
            ST_DEAD: begin
                if (dcnt == DEAD_LAST) begin
                    if (target > pos)      state_nx = ST_MOVE_UP;
                    else if (target < pos) state_nx = ST_MOVE_DN;
                    else                   state_nx = ST_IDLE;
                end
            end
            ST_MOVE_UP: begin
                if (top) begin
                    pos_nx   = POS_OPEN;
                    state_nx = ST_IDLE;
                end else begin
                    if (tick) pos_nx = pos_inc;
                    if (pos_nx == target)     state_nx = ST_IDLE;
                    else if (target < pos_nx) state_nx = ST_DEAD;
                end
            end
            ST_MOVE_DN: begin
                if (bot) begin
                    pos_nx   = '0;
                    state_nx = ST_IDLE;
                end else begin
                    if (tick) pos_nx = pos_dec;
                    if (pos_nx == target)     state_nx = ST_IDLE;
                    else if (target > pos_nx) state_nx = ST_DEAD;
                end
            end
            ST_FAULT: state_nx = ST_FAULT;
            default:  state_nx = ST_FAULT;
        endcase

        if (top && bot) begin
            state_nx = ST_FAULT;
            pos_nx   = pos;
        end
    end

    always_ff @(posedge reloj or posedge reset) begin
        if (reset) begin
            state <= ST_INIT;
            pos   <= '0;
        end else begin
            state <= state_nx;
            pos   <= pos_nx;
        end
    end

    // Prescaler restarts whenever a motion state is (re)entered.
    always_ff @(posedge reloj or posedge reset) begin
        if (reset) begin
            presc <= '0;
        end else if (motion && (state_nx == state)) begin
            presc <= tick ? '0 : presc + 1'b1;
        end else begin
            presc <= '0;
        end
    end

    always_ff @(posedge reloj or posedge reset) begin
        if (reset) begin
            dcnt <= '0;
        end else if (((state == ST_INIT) || (state == ST_DEAD)) && (state_nx == state)) begin
            dcnt <= dcnt + 1'b1;
        end else begin
            dcnt <= '0;
        end
    end

    always_ff @(posedge reloj or posedge reset) begin
        if (reset) begin
            htick <= '0;
        end else if (state == ST_HOME) begin
            if (tick) htick <= htick + 1'b1;
        end else begin
            htick <= '0;
        end
    end

    assign motor_up   = (state == ST_MOVE_UP);
    assign motor_down = (state == ST_MOVE_DN) || (state == ST_HOME);
    assign busy       = (state != ST_IDLE);
    assign fault      = (state == ST_FAULT);

endmodule
